reg_alu_pipe: RTL and testbench
===============================

# reg_alu_pipe

Parametrised successor to the 16-bit register-file/ALU datapath: a 2^AW-entry, W-bit register file fused with a 4-op ALU behind a two-stage, valid/ready-handshaked pipeline. It adds a carry flag (add-with-carry), write-back bypass, and output backpressure. It sits between the instruction sequencer (upstream, issues one operation per handshake) and the result sink (downstream).

## Interface
- W, 16, datapath / register width (≥ 2)
- AW, 3, register address width; depth N = 2**AW
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; all state cleared on a clk edge where reset==0
- in_valid  in  1  issue request
- in_ready  out  1  block can accept an issue this cycle
- op  in  2  00 ADD, 01 ADC, 10 SUB, 11 AND
- sel  in  1  write-back source: 0 = d_in, 1 = ALU result
- wr  in  1  write-back enable
- rd_addr_a, rd_addr_b  in  AW  operand addresses
- wr_addr  in  AW  write-back address
- d_in  in  W  external write data
- out_valid  out  1  EX stage holds a result
- out_ready  in  1  sink accepts result
- d_out_a, d_out_b  out  W  operands used by the EX-stage instruction (registered)
- result  out  W  ALU result of the EX-stage instruction
- cout  out  1  carry flag register (architectural)

## Operation
- Issue stage: on accept (in_valid && in_ready), read A and B with bypass, then latch op, sel, wr, wr_addr, d_in, and the operands into the EX register. ex_valid is set.
- in_ready = !ex_valid || out_ready (combinational). Accept and retire may occur on the same edge.
- EX stage: result is computed combinationally from the latched operands and the cout register.
  - ADD: {c,r} = A + B.
  - ADC: {c,r} = A + B + cout.
  - SUB: {c,r} = A + ~B + 1, so c = 1 means no borrow.
  - AND: r = A & B, c is unused.
  - All arithmetic is W+1 bits; r wraps modulo 2^W.
- Retire (out_valid && out_ready):
  - If wr, reg[wr_addr] ← (sel ? result : d_in).
  - For ADD/ADC/SUB, cout ← c. AND leaves cout unchanged. The cout update is independent of wr and sel.
  - ex_valid clears unless a new issue is accepted on the same edge.
- Bypass: if the retiring instruction writes address X and the instruction accepted on the same edge reads X, the accepted operand takes the written value, not the stale array value. This applies independently to A and B.
- While out_valid && !out_ready, all outputs are held stable, there is no write-back, and there is no cout update.
- No register is hardwired to zero. All N entries are writable.

## Timing
- Reset (reset==0 at an edge):
  - All registers and cout go to 0.
  - out_valid goes to 0, and d_out_a, d_out_b, result go to 0.
  - Any in-flight EX instruction is discarded with no write-back.
  - in_ready goes to 1 in the first cycle after reset releases.
- Latency: an instruction accepted at edge t drives out_valid and result after t. Its write-back takes effect at its retire edge, earliest t+1.
- Throughput: one instruction per cycle while out_ready = 1. Dependent back-to-back instructions incur no stall (via bypass).
- ADC in EX sees cout as updated by the immediately preceding retired instruction. No flag bypass is needed because EX holds one instruction.
- If in_valid is high while in_ready is low, nothing is captured and the upstream must hold its inputs.
- Address wrap: none. Addresses are exactly AW bits and all are valid.

## Test plan
- Reset/clear: hold reset=0 for 2 cycles, then issue ADD r0,r7 with sel=1, wr=0 -> result=0x0000, cout=0, out_valid=1 one cycle after accept.
- Load and carry chain (W=16):
  - Issue sel=0, wr=1, wr_addr=1, d_in=0x8000, then wr_addr=2, d_in=0x8001.
  - Then ADD r1,r2 into r3 -> result=0x0001, cout=1.
  - Then ADC r0,r0 -> result=0x0001, cout=0.
- Bypass: write r4=0x1234, then on the very next cycle ADD r4,r4 -> d_out_a=d_out_b=0x1234, result=0x2468, with in_ready never deasserted.
- Backpressure:
  - Issue sel=1, wr=1, wr_addr=5, ADD of 0x0003+0x0004, and hold out_ready=0 for 3 cycles.
  - During the hold: out_valid=1, result stays 0x0007, in_ready=0, and r5 is unchanged (0).
  - After raising out_ready, r5=0x0007 on the following read.
- SUB/AND with r1=5, r2=7:
  - SUB r1,r2 -> 0xFFFE, cout=0.
  - SUB r2,r1 -> 0x0002, cout=1.
  - AND r1,r2 -> 0x0005, cout stays 1.
- Reset mid-operation: with out_valid=1, a pending write to r6 and out_ready=0, assert reset=0 for one edge -> out_valid=0, r6 reads 0, cout=0. Repeat the load test with W=8, AW=2: 0x80+0x81 -> 0x01, cout=1.

Source files
------------

// File: rtl/reg_alu_pipe.sv
// Register file fused with a 4-op ALU behind a two-stage valid/ready pipeline.
// The write-back of the retiring instruction is bypassed into the issue-stage operand read.
module reg_alu_pipe #(
   parameter int unsigned W  = 16,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic          sel,
   input  logic          wr,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  d_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  d_out_a,
   output logic [W-1:0]  d_out_b,
   output logic [W-1:0]  result,
   output logic          cout
);

   localparam int unsigned N  = 1 << AW;
   localparam int unsigned SW = W + 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_ADC = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   logic [W-1:0]  regs_q [N];
   logic          cout_q, cout_d;
   logic          ex_valid_q, ex_valid_d;
   logic [1:0]    ex_op_q, ex_op_d;
   logic          ex_sel_q, ex_sel_d;
   logic          ex_wr_q, ex_wr_d;
   logic [AW-1:0] ex_wr_addr_q, ex_wr_addr_d;
   logic [W-1:0]  ex_d_in_q, ex_d_in_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;

   logic          accept, retire, wb_en, carry_en;
   logic [SW-1:0] sum;
   logic [W-1:0]  wb_data, rd_a, rd_b;

   assign in_ready = !ex_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign retire   = ex_valid_q && out_ready;

   // EX-stage ALU on latched operands; the carry is W+1 bit arithmetic
   always_comb begin
      sum      = '0;
      carry_en = 1'b1;
      case (ex_op_q)
         OP_ADD:  sum = {1'b0, a_q} + {1'b0, b_q};
         OP_ADC:  sum = {1'b0, a_q} + {1'b0, b_q} + SW'(cout_q);
         OP_SUB:  sum = {1'b0, a_q} + {1'b0, ~b_q} + SW'(1);
         OP_AND: begin
            sum      = {1'b0, a_q & b_q};
            carry_en = 1'b0;
         end
         default: sum = '0;
      endcase
   end

   assign wb_data = ex_sel_q ? sum[W-1:0] : ex_d_in_q;
   assign wb_en   = retire && ex_wr_q;

   // Operand read sees the value being written back on this same edge
   assign rd_a = (wb_en && (ex_wr_addr_q == rd_addr_a)) ? wb_data : regs_q[rd_addr_a];
   assign rd_b = (wb_en && (ex_wr_addr_q == rd_addr_b)) ? wb_data : regs_q[rd_addr_b];

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_op_d      = ex_op_q;
      ex_sel_d     = ex_sel_q;
      ex_wr_d      = ex_wr_q;
      ex_wr_addr_d = ex_wr_addr_q;
      ex_d_in_d    = ex_d_in_q;
      a_d          = a_q;
      b_d          = b_q;
      cout_d       = cout_q;
      if (retire) begin
         ex_valid_d = 1'b0;
         if (carry_en) cout_d = sum[W];
      end
      if (accept) begin
         ex_valid_d   = 1'b1;
         ex_op_d      = op;
         ex_sel_d     = sel;
         ex_wr_d      = wr;
         ex_wr_addr_d = wr_addr;
         ex_d_in_d    = d_in;
         a_d          = rd_a;
         b_d          = rd_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < N; i++) regs_q[i] <= '0;
         cout_q       <= 1'b0;
         ex_valid_q   <= 1'b0;
         ex_op_q      <= OP_ADD;
         ex_sel_q     <= 1'b0;
         ex_wr_q      <= 1'b0;
         ex_wr_addr_q <= '0;
         ex_d_in_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
      end else begin
         if (wb_en) regs_q[ex_wr_addr_q] <= wb_data;
         cout_q       <= cout_d;
         ex_valid_q   <= ex_valid_d;
         ex_op_q      <= ex_op_d;
         ex_sel_q     <= ex_sel_d;
         ex_wr_q      <= ex_wr_d;
         ex_wr_addr_q <= ex_wr_addr_d;
         ex_d_in_q    <= ex_d_in_d;
         a_q          <= a_d;
         b_q          <= b_d;
      end
   end

   assign out_valid = ex_valid_q;
   assign d_out_a   = a_q;
   assign d_out_b   = b_q;
   assign result    = sum[W-1:0];
   assign cout      = cout_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Bench for reg_alu_pipe: directed scenarios plus random traffic checked against a
// sequential instruction-level model (one instruction in flight means issue order == execution order).
module tb_reg_alu_pipe;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, sel, wr, out_valid, out_ready, cout;
   logic [1:0]  op;
   logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic [15:0] d_in, d_out_a, d_out_b, result;

   logic       s_reset, s_in_valid, s_in_ready, s_sel, s_wr, s_out_valid, s_out_ready, s_cout;
   logic [1:0] s_op, s_rd_addr_a, s_rd_addr_b, s_wr_addr;
   logic [7:0] s_d_in, s_d_out_a, s_d_out_b, s_result;

   always #5 clk = ~clk;

   reg_alu_pipe #(.W(16), .AW(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .sel(sel), .wr(wr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
      .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready), .d_out_a(d_out_a),
      .d_out_b(d_out_b), .result(result), .cout(cout)
   );

   reg_alu_pipe #(.W(8), .AW(2)) dut8 (
      .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
      .sel(s_sel), .wr(s_wr), .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
      .wr_addr(s_wr_addr), .d_in(s_d_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .d_out_a(s_d_out_a), .d_out_b(s_d_out_b), .result(s_result), .cout(s_cout)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Instruction-level reference model
   typedef struct {
      logic [1:0]  op;
      logic        sel, wr;
      logic [2:0]  ra, rb, wa;
      logic [15:0] din;
   } instr_t;

   instr_t      q[$];
   logic [15:0] m_regs [8];
   logic        m_cout = 1'b0;
   logic        chk_on = 1'b0;
   logic        m_ev, m_c;
   logic [15:0] m_r;
   instr_t      m_t;

   function automatic void exec(input instr_t t, output logic [15:0] r, output logic c);
      int unsigned a, b, s;
      a = m_regs[t.ra];
      b = m_regs[t.rb];
      c = m_cout;
      case (t.op)
         2'd0: begin s = a + b;          r = 16'(s); c = (s > 65535); end
         2'd1: begin s = a + b + m_cout; r = 16'(s); c = (s > 65535); end
         2'd2: begin r = 16'(a - b); c = (a >= b); end
         default: r = 16'(a & b);
      endcase
   endfunction

   always @(negedge clk) begin
      m_ev = (q.size() > 0);
      if (chk_on) begin
         chk("out_valid", 32'(out_valid), 32'(m_ev));
         chk("in_ready", 32'(in_ready), 32'(!m_ev || out_ready));
         chk("cout", 32'(cout), 32'(m_cout));
         if (m_ev) begin
            m_t = q[0];
            exec(m_t, m_r, m_c);
            chk("d_out_a", 32'(d_out_a), 32'(m_regs[m_t.ra]));
            chk("d_out_b", 32'(d_out_b), 32'(m_regs[m_t.rb]));
            chk("result", 32'(result), 32'(m_r));
         end
      end
      if (!reset) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
         m_cout = 1'b0;
         q.delete();
      end else begin
         if (m_ev && out_ready) begin
            m_t = q.pop_front();
            exec(m_t, m_r, m_c);
            if (m_t.wr) m_regs[m_t.wa] = m_t.sel ? m_r : m_t.din;
            if (m_t.op != 2'd3) m_cout = m_c;
         end
         if (in_valid && (!m_ev || out_ready))
            q.push_back('{op, sel, wr, rd_addr_a, rd_addr_b, wr_addr, d_in});
      end
   end

   task automatic settle();
      @(posedge clk); #1;
   endtask

   task automatic do_op(input logic [1:0] o, input logic s, input logic w,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wa,
                        input logic [15:0] din);
      op = o; sel = s; wr = w; rd_addr_a = ra; rd_addr_b = rb; wr_addr = wa; d_in = din;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic s_do_op(input logic [1:0] o, input logic s, input logic w,
                          input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] wa,
                          input logic [7:0] din);
      s_op = o; s_sel = s; s_wr = w; s_rd_addr_a = ra; s_rd_addr_b = rb; s_wr_addr = wa;
      s_d_in = din; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
   endtask

   logic stalled;

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'd0; sel = 1'b0; wr = 1'b0;
      rd_addr_a = 3'd0; rd_addr_b = 3'd0; wr_addr = 3'd0; d_in = 16'h0;
      s_reset = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_op = 2'd0; s_sel = 1'b0;
      s_wr = 1'b0; s_rd_addr_a = 2'd0; s_rd_addr_b = 2'd0; s_wr_addr = 2'd0; s_d_in = 8'h0;

      // reset and clear
      repeat (2) @(posedge clk);
      #1 reset = 1'b1; chk_on = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      settle();
      do_op(2'd0, 1'b1, 1'b0, 3'd0, 3'd7, 3'd0, 16'h0);
      @(negedge clk);
      chk("clr_valid", 32'(out_valid), 32'd1);
      chk("clr_result", 32'(result), 32'h0);
      settle();

      // load and carry chain
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 16'h8000);
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 16'h8001);
      do_op(2'd0, 1'b1, 1'b1, 3'd1, 3'd2, 3'd3, 16'h0);
      @(negedge clk);
      chk("add_result", 32'(result), 32'h0001);
      settle();
      do_op(2'd1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
      @(negedge clk);
      chk("add_cout", 32'(cout), 32'd1);
      chk("adc_result", 32'(result), 32'h0001);
      settle();
      @(negedge clk);
      chk("adc_cout", 32'(cout), 32'd0);
      settle();

      // back-to-back bypass
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 16'h1234);
      do_op(2'd0, 1'b1, 1'b0, 3'd4, 3'd4, 3'd0, 16'h0);
      @(negedge clk);
      chk("byp_a", 32'(d_out_a), 32'h1234);
      chk("byp_b", 32'(d_out_b), 32'h1234);
      chk("byp_result", 32'(result), 32'h2468);
      settle();

      // backpressure
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd6, 16'h0003);
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd7, 16'h0004);
      do_op(2'd0, 1'b1, 1'b1, 3'd6, 3'd7, 3'd5, 16'h0);
      out_ready = 1'b0;
      op = 2'd0; sel = 1'b0; wr = 1'b0; rd_addr_a = 3'd5; rd_addr_b = 3'd0; wr_addr = 3'd0;
      d_in = 16'hdead; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_result", 32'(result), 32'h0007);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      settle();
      out_ready = 1'b1;
      settle();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_r5", 32'(d_out_a), 32'h0007);
      settle();

      // SUB / AND
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 16'h0005);
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 16'h0007);
      do_op(2'd2, 1'b1, 1'b0, 3'd1, 3'd2, 3'd0, 16'h0);
      @(negedge clk);
      chk("sub12_result", 32'(result), 32'hfffe);
      settle();
      do_op(2'd2, 1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 16'h0);
      @(negedge clk);
      chk("sub12_cout", 32'(cout), 32'd0);
      chk("sub21_result", 32'(result), 32'h0002);
      settle();
      do_op(2'd3, 1'b1, 1'b0, 3'd1, 3'd2, 3'd0, 16'h0);
      @(negedge clk);
      chk("sub21_cout", 32'(cout), 32'd1);
      chk("and_result", 32'(result), 32'h0005);
      settle();
      @(negedge clk);
      chk("and_cout", 32'(cout), 32'd1);
      settle();

      // reset while an instruction is held
      do_op(2'd3, 1'b0, 1'b1, 3'd0, 3'd0, 3'd6, 16'h00aa);
      out_ready = 1'b0;
      @(negedge clk);
      chk("mid_valid", 32'(out_valid), 32'd1);
      settle();
      reset = 1'b0;
      settle();
      reset = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_cout", 32'(cout), 32'd0);
      settle();
      do_op(2'd0, 1'b1, 1'b0, 3'd6, 3'd0, 3'd0, 16'h0);
      @(negedge clk);
      chk("mid_r6", 32'(d_out_a), 32'h0);
      settle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         stalled = in_valid && !in_ready;
         @(posedge clk); #1;
         out_ready = ($urandom_range(3) != 0);
         if (!stalled) begin
            in_valid  = ($urandom_range(3) != 0);
            op        = 2'($urandom);
            sel       = 1'($urandom);
            wr        = ($urandom_range(3) != 0);
            rd_addr_a = 3'($urandom);
            rd_addr_b = 3'($urandom);
            wr_addr   = 3'($urandom);
            d_in      = ($urandom_range(7) == 0) ? 16'hffff : 16'($urandom);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) settle();

      // narrow instance: W=8, AW=2
      s_reset = 1'b1;
      @(negedge clk);
      chk("w8_rst_valid", 32'(s_out_valid), 32'd0);
      chk("w8_rst_cout", 32'(s_cout), 32'd0);
      settle();
      s_do_op(2'd3, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 8'h80);
      s_do_op(2'd3, 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 8'h81);
      s_do_op(2'd0, 1'b1, 1'b1, 2'd1, 2'd2, 2'd3, 8'h00);
      @(negedge clk);
      chk("w8_a", 32'(s_d_out_a), 32'h80);
      chk("w8_b", 32'(s_d_out_b), 32'h81);
      chk("w8_result", 32'(s_result), 32'h01);
      settle();
      @(negedge clk);
      chk("w8_cout", 32'(s_cout), 32'd1);
      chk("w8_drained", 32'(s_out_valid), 32'd0);
      settle();
      s_do_op(2'd0, 1'b1, 1'b0, 2'd3, 2'd3, 2'd0, 8'h00);
      @(negedge clk);
      chk("w8_r3", 32'(s_d_out_a), 32'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
